// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of an asynchronous PWM input,
// reporting one result per period and flagging inputs that stop toggling.
module pwm_capture #(
    parameter int CNT_WIDTH   = 8,
    parameter bit INV_IN      = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] level,
    output logic [CNT_WIDTH:0]   period,
    output logic                 valid,
    output logic                 stuck
);

    localparam int PW = CNT_WIDTH + 1;
    localparam logic [PW-1:0]        CNT_ONE = PW'(1);
    localparam logic [PW-1:0]        CNT_MAX = {PW{1'b1}};
    localparam logic [CNT_WIDTH-1:0] LVL_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2,
        STUCK     = 2'd3
    } state_t;

    // Front end: synchroniser, delayed copy, registered edge events
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   s_d_q, s_d_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   hi_q, hi_d;

    // Measurement counters and FSM
    logic [PW-1:0]          per_cnt_q, per_cnt_d;
    logic [PW-1:0]          hi_cnt_q, hi_cnt_d;
    logic [PW-1:0]          hi_lat_q, hi_lat_d;
    logic                   timeout;
    state_t                 state_q, state_d;

    logic                   emit;
    logic [CNT_WIDTH-1:0]   emit_level;
    logic [PW-1:0]          emit_period;
    logic                   emit_stuck;

    // Result stage and output registers
    logic                   res_valid_q, res_valid_d;
    logic [CNT_WIDTH-1:0]   res_level_q, res_level_d;
    logic [PW-1:0]          res_period_q, res_period_d;
    logic                   res_stuck_q, res_stuck_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   level_q, level_d;
    logic [PW-1:0]          period_q, period_d;
    logic                   stuck_q, stuck_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in ^ INV_IN};
        s      = sync_q[SYNC_STAGES-1];
        s_d_d  = s;
        rise_d = s & ~s_d_q;
        fall_d = ~s & s_d_q;
        hi_d   = s;
    end

    // Both counters restart at 1 on a rise so the rise cycle itself is counted.
    always_comb begin
        if (rise_q) begin
            per_cnt_d = CNT_ONE;
        end else if (per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + CNT_ONE;
        end else begin
            per_cnt_d = per_cnt_q;
        end

        if (rise_q) begin
            hi_cnt_d = CNT_ONE;
        end else if (hi_q && (hi_cnt_q != CNT_MAX)) begin
            hi_cnt_d = hi_cnt_q + CNT_ONE;
        end else begin
            hi_cnt_d = hi_cnt_q;
        end

        timeout = (per_cnt_q == CNT_MAX) && !rise_q;
    end

    always_comb begin
        state_d     = state_q;
        hi_lat_d    = hi_lat_q;
        emit        = 1'b0;
        emit_level  = '0;
        emit_period = '0;
        emit_stuck  = 1'b0;

        case (state_q)
            WAIT_EDGE: begin
                if (rise_q) begin
                    state_d = MEAS_HIGH;
                end else if (timeout) begin
                    state_d    = STUCK;
                    emit       = 1'b1;
                    emit_stuck = 1'b1;
                    emit_level = hi_q ? LVL_MAX : '0;
                end
            end
            MEAS_HIGH: begin
                if (fall_q) begin
                    state_d  = MEAS_LOW;
                    hi_lat_d = hi_cnt_q;
                end else if (timeout) begin
                    state_d    = STUCK;
                    emit       = 1'b1;
                    emit_stuck = 1'b1;
                    emit_level = LVL_MAX;
                end
            end
            MEAS_LOW: begin
                if (rise_q) begin
                    state_d     = MEAS_HIGH;
                    emit        = 1'b1;
                    emit_level  = hi_lat_q[CNT_WIDTH] ? LVL_MAX : hi_lat_q[CNT_WIDTH-1:0];
                    emit_period = per_cnt_q;
                end else if (timeout) begin
                    state_d    = STUCK;
                    emit       = 1'b1;
                    emit_stuck = 1'b1;
                end
            end
            STUCK: begin
                // Recovery is silent; the next full period clears stuck.
                if (rise_q) begin
                    state_d = MEAS_HIGH;
                end
            end
            default: begin
                state_d = WAIT_EDGE;
            end
        endcase
    end

    always_comb begin
        res_valid_d  = emit;
        res_level_d  = emit_level;
        res_period_d = emit_period;
        res_stuck_d  = emit_stuck;

        valid_d  = res_valid_q;
        level_d  = res_valid_q ? res_level_q  : level_q;
        period_d = res_valid_q ? res_period_q : period_q;
        stuck_d  = res_valid_q ? res_stuck_q  : stuck_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            s_d_q        <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            hi_q         <= 1'b0;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            hi_lat_q     <= '0;
            state_q      <= WAIT_EDGE;
            res_valid_q  <= 1'b0;
            res_level_q  <= '0;
            res_period_q <= '0;
            res_stuck_q  <= 1'b0;
            valid_q      <= 1'b0;
            level_q      <= '0;
            period_q     <= '0;
            stuck_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            s_d_q        <= s_d_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            hi_q         <= hi_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            hi_lat_q     <= hi_lat_d;
            state_q      <= state_d;
            res_valid_q  <= res_valid_d;
            res_level_q  <= res_level_d;
            res_period_q <= res_period_d;
            res_stuck_q  <= res_stuck_d;
            valid_q      <= valid_d;
            level_q      <= level_d;
            period_q     <= period_d;
            stuck_q      <= stuck_d;
        end
    end

    assign level  = level_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule
